alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the execute stage, extending the 4-bit ALU operation set with SLT/SLTU and with XLEN-generic datapaths. Logic and arithmetic ops complete in one cycle. Shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle, trading latency for area. Operands enter and results leave through independent valid/ready handshakes, so the pipeline can stall the block from either side.

---
 rtl/alu_mc.sv | 206 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle execute-stage ALU
//
// Logic, arithmetic and set-less-than ops finish in one cycle. Shifts use an
// iterative shifter that moves up to SHIFT_STEP bits per cycle. Operands and
// results each cross an independent valid/ready handshake.
//
// Parameters
//   XLEN        operand/result width (power of 2, >= 8)
//   SHIFT_STEP  bits shifted per SHIFT cycle (power of 2, 1..XLEN)
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset
//   in_valid     operation offered
//   in_ready     operation accepted this cycle (combinational from out_ready)
//   in_op        ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
//   in_a         operand A, shift source
//   in_b         operand B, low $clog2(XLEN) bits are the shift amount
//   out_valid    result available
//   out_ready    consumer takes the result
//   out_result   result
//   out_illegal  op code was illegal (out_result is then 0)
// -----------------------------------------------------------------------------
module alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    localparam int SHW  = $clog2(XLEN);
    localparam int SHW1 = SHW + 1;
    // One extra bit so SHIFT_STEP == XLEN is representable.
    localparam logic [SHW:0] STEP = SHW1'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [3:0]        op_q;
    logic [XLEN-1:0]   work;
    logic [SHW-1:0]    remaining;

    logic              accept;
    logic [SHW-1:0]    shamt_in;
    logic              start_shift;

    logic [XLEN-1:0]   alu_result;
    logic              alu_illegal;

    logic [SHW:0]      step_k;
    logic [SHW-1:0]    remaining_next;
    logic [XLEN-1:0]   work_next;
    logic              shift_last;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign accept      = in_valid && in_ready;
    assign shamt_in    = in_b[SHW-1:0];
    // A zero shift amount takes the single-cycle path and returns in_a.
    assign start_shift = accept && (in_op inside {OP_SLL, OP_SRL, OP_SRA})
                         && (shamt_in != '0);

    // ------------------------------------------------------------------
    // Single-cycle ALU on the incoming operands
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (in_op)
            OP_ADD:  alu_result = in_a + in_b;
            OP_SUB:  alu_result = in_a - in_b;
            OP_XOR:  alu_result = in_a ^ in_b;
            OP_OR:   alu_result = in_a | in_b;
            OP_AND:  alu_result = in_a & in_b;
            OP_SLL, OP_SRL, OP_SRA:
                     alu_result = in_a;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, in_a < in_b};
            default: alu_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative shifter step: never moves further than what remains
    // ------------------------------------------------------------------
    always_comb begin
        step_k         = ({1'b0, remaining} < STEP) ? {1'b0, remaining} : STEP;
        remaining_next = remaining - step_k[SHW-1:0];
        shift_last     = (remaining_next == '0);
        case (op_q)
            OP_SLL:  work_next = work << step_k;
            OP_SRA:  work_next = $signed(work) >>> step_k;
            default: work_next = work >> step_k;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = start_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // A new op may be taken in the same cycle the result leaves.
                if (accept) begin
                    next_state = start_shift ? SHIFT : DONE;
                end else if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
        out_valid = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_ADD;
            work        <= '0;
            remaining   <= '0;
            out_result  <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            op_q <= in_op;
            if (start_shift) begin
                work      <= in_a;
                remaining <= shamt_in;
            end else begin
                out_result  <= alu_result;
                out_illegal <= alu_illegal;
            end
        end else if (state == SHIFT) begin
            work      <= work_next;
            remaining <= remaining_next;
            if (shift_last) begin
                out_result  <= work_next;
                out_illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- self-checking bench for alu_mc
//
// Two instances: index 0 with SHIFT_STEP=1, index 1 with SHIFT_STEP=8.
// Each instance has a scoreboard fed from accepted operations through an
// arithmetic model; its compare process checks out_valid, in_ready and the
// presented result every cycle. Directed vectors also carry hand-computed
// results and latencies.
// -----------------------------------------------------------------------------
module tb_alu_mc;

    localparam int XLEN = 32;
    localparam int NDUT = 2;

    logic            clk;
    logic            rst;
    logic            iv   [NDUT];
    logic            ir   [NDUT];
    logic [3:0]      iop  [NDUT];
    logic [XLEN-1:0] ia   [NDUT];
    logic [XLEN-1:0] ib   [NDUT];
    logic            ov   [NDUT];
    logic            ordy [NDUT];
    logic [XLEN-1:0] ores [NDUT];
    logic            oill [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit drain_check = 1'b0;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            ill;
        int              due;
    } exp_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] model_result(input logic [3:0] op,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $signed(a) >>> sh;
            4'd8:    return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9:    return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_illegal(input logic [3:0] op);
        return op > 4'd9;
    endfunction

    function automatic int model_latency(input logic [3:0] op,
                                         input logic [XLEN-1:0] b,
                                         input int step);
        int sh;
        sh = int'(b[4:0]);
        if (op >= 4'd5 && op <= 4'd7 && sh != 0) return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    // ------------------------------------------------------------------
    // DUTs and per-instance compare process
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NDUT; g++) begin : inst
        localparam int STEP = (g == 0) ? 1 : 8;

        alu_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .in_op      (iop[g]),
            .in_a       (ia[g]),
            .in_b       (ib[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .out_result (ores[g]),
            .out_illegal(oill[g])
        );

        exp_t q[$];
        bit   drained = 1'b0;

        always @(negedge clk) begin
            logic exp_valid;
            logic exp_ready;
            if (cyc > 0) begin
                exp_valid = (q.size() > 0) && (cyc >= q[0].due);
                exp_ready = !rst && ((q.size() == 0) || (exp_valid && ordy[g]));
                check($sformatf("d%0d out_valid @%0d", g, cyc), XLEN'(ov[g]), XLEN'(exp_valid));
                check($sformatf("d%0d in_ready @%0d", g, cyc), XLEN'(ir[g]), XLEN'(exp_ready));
                if (exp_valid) begin
                    check($sformatf("d%0d out_result @%0d", g, cyc), ores[g], q[0].res);
                    check($sformatf("d%0d out_illegal @%0d", g, cyc), XLEN'(oill[g]), XLEN'(q[0].ill));
                end
                if (rst) begin
                    q.delete();
                end else begin
                    if (exp_valid && ordy[g]) void'(q.pop_front());
                    if (iv[g] && exp_ready) begin
                        q.push_back('{res: model_result(iop[g], ia[g], ib[g]),
                                      ill: model_illegal(iop[g]),
                                      due: cyc + model_latency(iop[g], ib[g], STEP)});
                    end
                end
                if (drain_check && !drained) begin
                    drained = 1'b1;
                    check($sformatf("d%0d results outstanding", g), XLEN'(q.size()), 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (entered and left just after a rising edge)
    // ------------------------------------------------------------------
    task automatic issue(input int d, input logic [3:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         output int n);
        logic acc;
        iop[d] = op;
        ia[d]  = a;
        ib[d]  = b;
        iv[d]  = 1'b1;
        n      = 0;
        acc    = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ir[d];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check($sformatf("d%0d accept timeout", d), 0, 1);
        iv[d]  = 1'b0;
        iop[d] = 4'($urandom);
        ia[d]  = $urandom;
        ib[d]  = $urandom;
    endtask

    task automatic run_op(input int d, input logic [3:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_res, input logic exp_ill,
                          input int exp_lat, input string name);
        int n;
        int lat;
        issue(d, op, a, b, n);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[d] && lat < 100);
        check({name, " latency"}, XLEN'(lat), XLEN'(exp_lat));
        check({name, " result"}, ores[d], exp_res);
        check({name, " illegal"}, XLEN'(oill[d]), XLEN'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; iop[d] = '0; ia[d] = '0; ib[d] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", XLEN'(ov[0]), 0);
        check("reset out_result", ores[0], 0);
        check("reset out_illegal", XLEN'(oill[0]), 0);
        check("reset in_ready", XLEN'(ir[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", XLEN'(ir[0]), 1);
        @(posedge clk);
        #1;

        // Single-cycle ops
        run_op(0, 4'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1, "add");
        run_op(0, 4'd1, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1, "sub");
        run_op(0, 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1, "xor");
        run_op(0, 4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1, "or");
        run_op(0, 4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, "and");
        run_op(0, 4'd8, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1, "slt neg");
        run_op(0, 4'd9, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1, "sltu");
        run_op(0, 4'd8, 32'h5,        32'h5,        32'h0,        1'b0, 1, "slt eq");

        // Shifts, SHIFT_STEP=1
        run_op(0, 4'd7, 32'h80000000, 32'd4,  32'hF8000000, 1'b0, 5,  "sra 4");
        run_op(0, 4'd6, 32'h80000000, 32'd4,  32'h08000000, 1'b0, 5,  "srl 4");
        run_op(0, 4'd5, 32'h1,        32'd31, 32'h80000000, 1'b0, 32, "sll 31");
        run_op(0, 4'd5, 32'hDEADBEEF, 32'd32, 32'hDEADBEEF, 1'b0, 1,  "sll 32");

        // Shifts, SHIFT_STEP=8 (partial final step)
        run_op(1, 4'd5, 32'h1,        32'd13, 32'h00002000, 1'b0, 3, "s8 sll 13");
        run_op(1, 4'd7, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 5, "s8 sra 31");
        run_op(1, 4'd6, 32'hFFFFFFFF, 32'd8,  32'h00FFFFFF, 1'b0, 2, "s8 srl 8");

        // Illegal op, then a legal op clears the flag
        run_op(0, 4'd12, 32'h1234, 32'h5678, 32'h0, 1'b1, 1, "illegal 12");
        run_op(0, 4'd0,  32'h2,    32'h2,    32'h4, 1'b0, 1, "add after illegal");

        // Backpressure: result held for 5 cycles, no new accept
        ordy[0] = 1'b0;
        issue(0, 4'd0, 32'd100, 32'd23, n);
        iv[0] = 1'b1;
        iop[0] = 4'd0; ia[0] = 32'd7; ib[0] = 32'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall out_valid", XLEN'(ov[0]), 1);
            check("stall out_result", ores[0], 32'd123);
            check("stall in_ready", XLEN'(ir[0]), 0);
        end
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;

        // Stream of 4 ADDs, each accepted in one cycle
        for (int i = 1; i <= 4; i++) begin
            issue(0, 4'd0, XLEN'(i * 1000), XLEN'(i), n);
            check($sformatf("stream accept %0d cycles", i), XLEN'(n), 1);
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset on the 3rd SHIFT cycle discards the pending result
        issue(0, 4'd5, 32'h1, 32'd20, n);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_ready during reset", XLEN'(ir[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("out_valid after mid-shift reset", XLEN'(ov[0]), 0);
        check("in_ready after mid-shift reset", XLEN'(ir[0]), 1);
        @(posedge clk);
        #1;
        run_op(0, 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, "add after reset");

        // Let any stray result show up, then confirm scoreboards are empty
        repeat (30) @(posedge clk);
        #1;
        drain_check = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
